// File: rtl/pcs_tx_sequencer.sv
// Transmit slot scheduler for a 32-bit 10GBASE-R PCS: owns the 33-slot gearbox schedule,
// back-pressures the MAC, keeps 66-bit blocks atomic and fills empty slots with idle.
module pcs_tx_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SEQ_MAX    = 32,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 32'h07070707
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_mac_data,
  input  logic [3:0]            i_mac_ctrl,
  input  logic                  i_mac_valid,
  output logic                  o_mac_ready,
  output logic [DATA_WIDTH-1:0] o_enc_data,
  output logic [3:0]            o_enc_ctrl,
  output logic                  o_enc_valid,
  output logic                  o_enc_half,
  output logic [5:0]            o_gb_seq,
  output logic                  o_gb_hdr_valid,
  output logic                  o_underflow,
  output logic [15:0]           o_idle_cnt
);

  localparam logic [5:0] PAUSE_SLOT = 6'(SEQ_MAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [5:0]            slot_q;
  logic [5:0]            slot_d;
  logic                  first_idle_q;
  logic                  first_idle_d;
  logic                  ready_s;
  logic                  insert_idle_s;
  logic                  odd_slot_s;
  logic                  pause_slot_s;
  logic [DATA_WIDTH-1:0] data_d;
  logic [3:0]            ctrl_d;
  logic                  valid_d;
  logic                  half_d;
  logic [5:0]            seq_d;
  logic                  underflow_d;
  logic [15:0]           idle_cnt_d;

  assign odd_slot_s   = slot_q[0];
  assign pause_slot_s = (slot_q == PAUSE_SLOT);
  assign o_mac_ready  = ready_s;

  // Next-state, MAC handshake and next output word for the current slot
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    first_idle_d  = first_idle_q;
    ready_s       = 1'b0;
    insert_idle_s = 1'b0;
    data_d        = o_enc_data;
    ctrl_d        = o_enc_ctrl;
    valid_d       = 1'b0;
    half_d        = 1'b0;
    seq_d         = 6'd0;
    underflow_d   = 1'b0;
    idle_cnt_d    = o_idle_cnt;

    case (state_q)
      ST_IDLE: begin
        slot_d       = 6'd0;
        first_idle_d = 1'b0;
        if (i_enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Stop only on a block boundary so a started block always gets its second half
        if (!i_enable && (!odd_slot_s || pause_slot_s)) begin
          state_d      = ST_IDLE;
          slot_d       = 6'd0;
          first_idle_d = 1'b0;
        end else if (pause_slot_s) begin
          slot_d = 6'd0;
          seq_d  = PAUSE_SLOT;
        end else begin
          slot_d  = slot_q + 6'd1;
          ready_s = (i_enable || odd_slot_s) && !(odd_slot_s && first_idle_q);
          valid_d = 1'b1;
          half_d  = odd_slot_s;
          seq_d   = slot_q;
          if (ready_s && i_mac_valid) begin
            data_d = i_mac_data;
            ctrl_d = i_mac_ctrl;
          end else begin
            insert_idle_s = 1'b1;
            data_d        = IDLE_WORD;
            ctrl_d        = 4'hF;
            underflow_d   = odd_slot_s && !first_idle_q && !i_mac_valid;
            if (o_idle_cnt != 16'hFFFF) begin
              idle_cnt_d = o_idle_cnt + 16'd1;
            end else begin
              idle_cnt_d = o_idle_cnt;
            end
          end
          if (!odd_slot_s) begin
            first_idle_d = insert_idle_s;
          end else begin
            first_idle_d = first_idle_q;
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        slot_d       = 6'd0;
        first_idle_d = 1'b0;
      end
    endcase
  end

  // State and registered output word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      slot_q         <= 6'd0;
      first_idle_q   <= 1'b0;
      o_enc_data     <= '0;
      o_enc_ctrl     <= 4'h0;
      o_enc_valid    <= 1'b0;
      o_enc_half     <= 1'b0;
      o_gb_seq       <= 6'd0;
      o_gb_hdr_valid <= 1'b0;
      o_underflow    <= 1'b0;
      o_idle_cnt     <= 16'd0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      first_idle_q   <= first_idle_d;
      o_enc_data     <= data_d;
      o_enc_ctrl     <= ctrl_d;
      o_enc_valid    <= valid_d;
      o_enc_half     <= half_d;
      o_gb_seq       <= seq_d;
      o_gb_hdr_valid <= valid_d && !half_d;
      o_underflow    <= underflow_d;
      o_idle_cnt     <= idle_cnt_d;
    end
  end

endmodule
